// File: rtl/cl_div_26bit.sv
// Bit-serial carry-less (GF(2)[x]) polynomial divider: one dividend bit per clock,
// producing quotient and remainder with dividend = quotient*divisor ^ remainder.
module cl_div_26bit #(
    parameter int N = 26,
    parameter int M = 2*N-1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [M-1:0] quotient,
    output logic [N-2:0] remainder
);

    localparam int DW = $clog2(N);
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state;
    logic [M-1:0]   w;
    logic [N-1:0]   dreg;
    logic [DW-1:0]  d_idx;
    logic [N-1:0]   r;
    logic [M-1:0]   q;
    logic [CW-1:0]  cnt;
    logic           dz_pend;

    logic [DW-1:0]  msb;
    logic [N-1:0]   t;
    logic           hit;
    logic [N-1:0]   r_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        msb = '0;
        for (int i = 0; i < N; i++) begin
            if (divisor[i]) msb = DW'(i);
        end
    end

    // One long-division step: bring down the next dividend bit, subtract (XOR)
    // the divisor whenever the leading coefficient lines up with its degree.
    always_comb begin
        t      = {r[N-2:0], w[cnt]};
        hit    = t[d_idx];
        r_next = hit ? (t ^ dreg) : t;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w         <= '0;
            dreg      <= '0;
            d_idx     <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            dz_pend   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w       <= dividend;
                        dreg    <= divisor;
                        d_idx   <= msb;
                        r       <= '0;
                        q       <= '0;
                        cnt     <= CW'(M-1);
                        dz_pend <= (divisor == '0);
                        state   <= (divisor == '0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    busy <= 1'b1;
                    r    <= r_next;
                    q    <= {q[M-2:0], hit};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) state <= FIN;
                end
                FIN: begin
                    quotient  <= q;
                    remainder <= r[N-2:0];
                    div_zero  <= dz_pend;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_div_26bit.sv
// Self-checking bench for cl_div_26bit: directed cases plus random operands
// compared against a polynomial long-division model and a carry-less product.
module tb_cl_div_26bit;

    localparam int N = 26;
    localparam int M = 51;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [M-1:0] quotient;
    logic [N-2:0] remainder;

    int n_vec = 0;
    int n_err = 0;

    cl_div_26bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int deg(input logic [79:0] v);
        deg = -1;
        for (int i = 0; i < 80; i++) if (v[i]) deg = i;
    endfunction

    // Textbook GF(2) long division on the whole dividend at once.
    function automatic void ref_div(input logic [M-1:0] a, input logic [N-1:0] b,
                                    output logic [M-1:0] q, output logic [N-2:0] r);
        logic [M-1:0] rem;
        int db;
        rem = a;
        q   = '0;
        db  = deg(80'(b));
        for (int i = M-1; i >= db; i--) begin
            if (rem[i]) begin
                rem ^= (M'(b) << (i - db));
                q[i-db] = 1'b1;
            end
        end
        r = rem[N-2:0];
    endfunction

    function automatic logic [79:0] clmul(input logic [M-1:0] a, input logic [N-1:0] b);
        logic [79:0] p;
        p = '0;
        for (int i = 0; i < M; i++) if (a[i]) p ^= (80'(b) << i);
        return p;
    endfunction

    task automatic run_div(input logic [M-1:0] a, input logic [N-1:0] b,
                           output int lat, output int bcnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = M'({$urandom, $urandom});
        divisor  = N'($urandom);
        lat  = 0;
        bcnt = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        if (!done) check("timeout_done", 80'(0), 80'(1));
    endtask

    task automatic check_result(input string tag, input logic [M-1:0] a, input logic [N-1:0] b);
        logic [M-1:0] eq;
        logic [N-2:0] er;
        ref_div(a, b, eq, er);
        check({tag, "_quot"}, 80'(quotient), 80'(eq));
        check({tag, "_rem"}, 80'(remainder), 80'(er));
        check({tag, "_dz"}, 80'(div_zero), 80'(0));
        check({tag, "_ident"}, clmul(quotient, b) ^ 80'(remainder), 80'(a));
        check({tag, "_deg"}, 80'(deg(80'(remainder)) < deg(80'(b))), 80'(1));
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [M-1:0] a0, a;
        logic [N-1:0] b0, b;
        logic [M-1:0] cq;
        logic [N-2:0] cr;
        logic         cdz;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_done", 80'(done), 80'(0));
        check("rst_dz", 80'(div_zero), 80'(0));
        check("rst_quot", 80'(quotient), 80'(0));
        check("rst_rem", 80'(remainder), 80'(0));
        @(negedge clk);
        rst = 1'b0;

        run_div(M'(51'h9), N'(26'h7), lat, bcnt);
        check("lat_9_7", 80'(lat), 80'(52));
        check("busy_9_7", 80'(bcnt), 80'(51));
        check("quot_9_7", 80'(quotient), 80'(3));
        check("rem_9_7", 80'(remainder), 80'(0));
        check("dz_9_7", 80'(div_zero), 80'(0));
        @(posedge clk);
        #1;
        check("done_pulse", 80'(done), 80'(0));

        run_div(M'(51'hB), N'(26'h3), lat, bcnt);
        check("quot_b_3", 80'(quotient), 80'(6));
        check("rem_b_3", 80'(remainder), 80'(1));

        run_div(51'h7FFFFFFFFFFFF, 26'h2000000, lat, bcnt);
        check("quot_top", 80'(quotient), 80'(26'h3FFFFFF));
        check("rem_top", 80'(remainder), 80'(25'h1FFFFFF));
        check_result("top", 51'h7FFFFFFFFFFFF, 26'h2000000);

        run_div(51'h5A5A5A5A5A5A5, N'(26'h1), lat, bcnt);
        check("quot_one", 80'(quotient), 80'(51'h5A5A5A5A5A5A5));
        check("rem_one", 80'(remainder), 80'(0));

        run_div(M'(51'h123), N'(26'h0), lat, bcnt);
        check("lat_dz", 80'(lat), 80'(1));
        check("dz_set", 80'(div_zero), 80'(1));
        check("quot_dz", 80'(quotient), 80'(0));
        check("rem_dz", 80'(remainder), 80'(0));
        @(posedge clk);
        #1;
        check("dz_hold", 80'(div_zero), 80'(1));
        run_div(M'(51'h9), N'(26'h3), lat, bcnt);
        check("dz_clear", 80'(div_zero), 80'(0));
        check_result("after_dz", M'(51'h9), N'(26'h3));

        // Extra start pulses during CALC and FIN must be ignored.
        a0 = M'({$urandom, $urandom});
        b0 = N'($urandom) | N'(26'h1000);
        @(negedge clk);
        dividend = a0;
        divisor  = b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start    = (c == 5 || c == 20 || c == 52);
            dividend = M'({$urandom, $urandom});
            divisor  = N'($urandom) | N'(1);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                cq  = quotient;
                cr  = remainder;
                cdz = div_zero;
            end
        end
        start = 1'b0;
        check("ignore_ndone", 80'(ndone), 80'(1));
        begin
            logic [M-1:0] eq;
            logic [N-2:0] er;
            ref_div(a0, b0, eq, er);
            check("ignore_quot", 80'(cq), 80'(eq));
            check("ignore_rem", 80'(cr), 80'(er));
            check("ignore_dz", 80'(cdz), 80'(0));
        end

        // Asynchronous abort in the middle of a division.
        @(negedge clk);
        dividend = M'({$urandom, $urandom});
        divisor  = N'($urandom) | N'(26'h800);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 80'(busy), 80'(0));
        check("abort_done", 80'(done), 80'(0));
        check("abort_quot", 80'(quotient), 80'(0));
        check("abort_rem", 80'(remainder), 80'(0));
        check("abort_dz", 80'(div_zero), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        a = M'({$urandom, $urandom});
        b = N'($urandom) | N'(26'h40);
        run_div(a, b, lat, bcnt);
        check("post_rst_lat", 80'(lat), 80'(52));
        check_result("post_rst", a, b);

        for (int i = 0; i < 1000; i++) begin
            int k;
            k = $urandom_range(1, N);
            a = M'({$urandom, $urandom});
            b = N'($urandom) & N'((64'd1 << k) - 64'd1);
            b[k-1] = 1'b1;
            run_div(a, b, lat, bcnt);
            check("rnd_lat", 80'(lat), 80'(52));
            check_result("rnd", a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
